// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter serialising per-core L1 requests onto the shared coherence bus.
// Optional forced release of long-held grants is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
    parameter int unsigned CPUS          = 8,
    parameter int unsigned CPU_ID_LENGTH = $clog2(CPUS),
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          req,
    input  logic                     done,
    output logic [CPUS-1:0]          grant,
    output logic [CPU_ID_LENGTH-1:0] grant_id,
    output logic                     grant_valid,
    output logic                     timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [CPUS-1:0]          grant_q;
    logic [CPU_ID_LENGTH-1:0] grant_id_q;
    logic                     grant_valid_q;
    logic [CPU_ID_LENGTH-1:0] ptr_q;

    logic                     win_found;
    logic [CPU_ID_LENGTH-1:0] grant_id_d;
    logic [CPU_ID_LENGTH-1:0] scan_idx;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(TIMEOUT) + 1;

    logic [TCW-1:0] tcnt_q;
    logic           timeout_q;
    logic           tmo_hit;

    assign tmo_hit = (tcnt_q == TCW'(TIMEOUT - 1));
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Scan starts one past the last winner and wraps modulo CPUS, so any CPUS works.
    always_comb begin
        win_found  = 1'b0;
        grant_id_d = '0;
        scan_idx   = '0;
        for (int unsigned i = 1; i <= CPUS; i++) begin
            scan_idx = CPU_ID_LENGTH'((32'(ptr_q) + i) % CPUS);
            if (!win_found && req[scan_idx]) begin
                win_found  = 1'b1;
                grant_id_d = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= CPU_ID_LENGTH'(CPUS - 1);
`ifdef BUS_ARB_TIMEOUT_EN
            tcnt_q        <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        grant_q       <= CPUS'(1) << grant_id_d;
                        grant_id_q    <= grant_id_d;
                        grant_valid_q <= 1'b1;
                        ptr_q         <= grant_id_d;
                        state_q       <= GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
                        tcnt_q        <= '0;
`endif
                    end
                end
                GRANT: begin
                    // done outranks a timeout landing on the same cycle
                    if (done) begin
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        state_q       <= RELEASE;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        timeout_q     <= 1'b1;
                        state_q       <= RELEASE;
                    end else begin
                        tcnt_q <= tcnt_q + TCW'(1);
                    end
`endif
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter that serialises L1 cache requests onto the shared coherence bus controller. It takes one request line per CPU, grants exactly one requester at a time, and holds that grant until the bus controller signals transaction completion. It sits between the per-core L1 request signals and the bus controller's single-requester front end.

## Interface

- CPUS, 8, number of L1 requesters
- CPU_ID_LENGTH, $clog2(CPUS), width of the granted CPU index
- TIMEOUT, 64, cycles a grant may be held before forced release (used only with BUS_ARB_TIMEOUT_EN)

- clk  input  1  bus clock
- nRST  input  1  asynchronous, active-low reset
- req  input  CPUS  per-core request (dREN | dWEN | ccwrite of that core), level, held until granted
- done  input  1  one-cycle pulse from the bus controller: granted transaction finished
- grant  output  CPUS  one-hot grant, all zero when nothing is granted
- grant_id  output  CPU_ID_LENGTH  index of the granted core; holds its last value when grant_valid=0
- grant_valid  output  1  a grant is active
- timeout  output  1  one-cycle pulse on a forced release (tied 0 without the macro)

## Operation

- States: IDLE, GRANT, RELEASE (2-bit encoded).
- IDLE: if req != 0, select the first set bit scanning from (ptr+1) mod CPUS upward with wrap. Register grant/grant_id, set grant_valid, set ptr to the winner, go to GRANT. If req == 0, stay in IDLE.
- GRANT: hold grant regardless of req. Deassertion of req by the granted core is ignored. On done, clear grant and grant_valid, go to RELEASE.
- RELEASE: one bubble cycle so the bus controller returns to its idle state. Always go to IDLE. req is not sampled.
- done in IDLE or RELEASE is ignored.
- ptr is a CPU_ID_LENGTH register. The scan is modulo CPUS, so wrap works for non-power-of-two CPUS.
- Exactly one grant bit is ever set. grant == (grant_valid ? 1<<grant_id : 0).

## Timing

- Reset (async, nRST=0): state=IDLE, grant=0, grant_id=0, grant_valid=0, timeout=0, ptr=CPUS-1, so core 0 has first priority.
- Latency: req sampled in IDLE at edge N gives grant visible after edge N (registered output), i.e. one cycle.
- done sampled at edge M gives grant=0 after M, RELEASE during cycle M+1, and a new grant at the earliest after edge M+2.
- Minimum grant-to-grant spacing: 3 cycles (GRANT of at least 1 cycle, RELEASE, IDLE).
- Reset asserted mid-GRANT: the grant drops immediately (asynchronously) and there is no timeout pulse.
- done and a new req from the same core in the same cycle: done wins, and that core is lowest priority in the next arbitration.

## Configuration

- BUS_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to GRANT and increments every GRANT cycle.
  - When the count reaches TIMEOUT-1 without done, the arbiter releases the grant as if done had arrived, pulses timeout for one cycle, and goes to RELEASE.
  - If done arrives on that same cycle, done takes precedence and there is no timeout pulse.
- BUS_ARB_TIMEOUT_EN undefined: no counter; timeout is tied to 0; the grant is held indefinitely until done.

## Test plan

- Reset: drive nRST=0 with req=0xFF → grant=0x00, grant_id=0, grant_valid=0, timeout=0. Release reset → first grant is 0x01.
- Single requester: req=0x08 in IDLE → one cycle later grant=0x08, grant_id=3. Drop req for 5 cycles with no done → grant stays 0x08. Pulse done → grant=0 next cycle, no new grant without req.
- Fairness: req=0xFF held, done pulsed 2 cycles after every grant → grant_id sequence 0,1,2,3,4,5,6,7,0, with 3+ cycle spacing.
- Wrap: last winner 7, req=0x81 → grant_id=0. Then done → grant_id=7.
- done while IDLE plus a mid-GRANT reset: the stray done produces no state change. nRST low during GRANT clears grant in the same cycle, and ptr returns to CPUS-1.
- Timeout (macro on, TIMEOUT=64): grant core 2 with no done → after 64 GRANT cycles, timeout pulses once, grant=0, and the next grant goes to the next requester above 2.
